hilo_muldiv: RTL and testbench

- Owns the architectural HI/LO register pair.
- Serves the ALU's HI/LO interface: supplies HI/LO to the ALU for MFHI/MFLO, and accepts direct HI/LO writes for MTHI/MTLO.
- Also runs unsigned MULTU/DIVU as iterative 32-cycle operations that write HI/LO on completion.
- Sits beside the ALU in the execute stage. Drives `busy` so the pipeline stalls while an operation is in flight.

---
 rtl/hilo_muldiv.sv | 212 +++++++++++++++++++++
 tb/tb_hilo_muldiv.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// ----------------------------------------------------------------------------
// hilo_muldiv
//
// Architectural HI/LO register pair with an iterative unsigned multiply /
// divide engine, placed beside the ALU in the execute stage.
//
//   MFHI/MFLO : hi/lo are always visible to the ALU.
//   MTHI/MTLO : w_hilo loads write_hi/write_lo, aborting any operation.
//   MULTU     : shift-add, one multiplier bit per cycle (LSB first).
//   DIVU      : restoring division, one quotient bit per cycle (MSB first).
//               A zero divisor completes immediately with hi = dividend and
//               lo = all ones.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous reset, active high
//   start     in   begin operation (sampled only in IDLE)
//   op        in   2'b01 MULTU, 2'b10 DIVU, others ignored
//   src_a     in   multiplicand / dividend
//   src_b     in   multiplier / divisor
//   w_hilo    in   direct HI/LO write strobe
//   write_hi  in   value for HI on w_hilo
//   write_lo  in   value for LO on w_hilo
//   hi        out  registered HI
//   lo        out  registered LO
//   busy      out  high while an operation is iterating
//   done      out  one-cycle pulse after HI/LO receive an operation result
// ----------------------------------------------------------------------------
module hilo_muldiv #(
    parameter int LENGTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [LENGTH-1:0] src_a,
    input  logic [LENGTH-1:0] src_b,
    input  logic              w_hilo,
    input  logic [LENGTH-1:0] write_hi,
    input  logic [LENGTH-1:0] write_lo,
    output logic [LENGTH-1:0] hi,
    output logic [LENGTH-1:0] lo,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LENGTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [CNT_W-1:0]  cnt_r;
    // a_r: multiplicand, or dividend shifting out MSB-first while quotient
    //      bits shift in at the bottom.
    // b_r: multiplier shifting out LSB-first while low product bits shift in
    //      at the top, or the divisor.
    // part_r: running high product half, or the partial remainder.
    logic [LENGTH-1:0] a_r;
    logic [LENGTH-1:0] b_r;
    logic [LENGTH-1:0] part_r;
    logic [LENGTH-1:0] hi_r;
    logic [LENGTH-1:0] lo_r;
    logic              busy_r;
    logic              done_r;

    logic              accept_mul_s;
    logic              accept_div_s;
    logic              div_zero_s;
    logic              finish_s;

    logic [LENGTH:0]   mul_sum_s;
    logic [LENGTH-1:0] mul_hi_next_s;
    logic [LENGTH-1:0] mul_lo_next_s;
    logic [LENGTH:0]   div_shift_s;
    logic              div_ge_s;
    logic [LENGTH-1:0] div_diff_s;
    logic [LENGTH-1:0] rem_next_s;
    logic [LENGTH-1:0] quo_next_s;

    assign hi   = hi_r;
    assign lo   = lo_r;
    assign busy = busy_r;
    assign done = done_r;

    // One iteration step of each engine, evaluated from the working registers.
    always_comb begin
        mul_sum_s     = {1'b0, part_r} + {1'b0, (b_r[0] ? a_r : {LENGTH{1'b0}})};
        mul_hi_next_s = mul_sum_s[LENGTH:1];
        mul_lo_next_s = {mul_sum_s[0], b_r[LENGTH-1:1]};
        div_shift_s   = {part_r, a_r[LENGTH-1]};
        div_ge_s      = (div_shift_s >= {1'b0, b_r});
        // Only used when the shifted remainder is >= divisor, so the true
        // difference is below the divisor and fits in LENGTH bits.
        div_diff_s    = div_shift_s[LENGTH-1:0] - b_r;
        rem_next_s    = div_ge_s ? div_diff_s : div_shift_s[LENGTH-1:0];
        quo_next_s    = {a_r[LENGTH-2:0], div_ge_s};
    end

    // Next-state logic; a direct HI/LO write overrides everything else.
    always_comb begin
        state_next_s = state_r;
        accept_mul_s = 1'b0;
        accept_div_s = 1'b0;
        div_zero_s   = 1'b0;
        finish_s     = 1'b0;
        if (w_hilo) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && (op == OP_MULTU)) begin
                        accept_mul_s = 1'b1;
                        state_next_s = ST_MUL;
                    end else if (start && (op == OP_DIVU)) begin
                        if (src_b != {LENGTH{1'b0}}) begin
                            accept_div_s = 1'b1;
                            state_next_s = ST_DIV;
                        end else begin
                            div_zero_s   = 1'b1;
                        end
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (cnt_r == CNT_LAST) begin
                        finish_s     = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = state_r;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register and the busy flag that mirrors it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
        end
    end

    // Operand capture and per-cycle iteration of the working registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= {LENGTH{1'b0}};
            b_r    <= {LENGTH{1'b0}};
            part_r <= {LENGTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
        end else if (accept_mul_s || accept_div_s) begin
            a_r    <= src_a;
            b_r    <= src_b;
            part_r <= {LENGTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
        end else if (state_r == ST_MUL) begin
            part_r <= mul_hi_next_s;
            b_r    <= mul_lo_next_s;
            cnt_r  <= cnt_r + CNT_ONE;
        end else if (state_r == ST_DIV) begin
            part_r <= rem_next_s;
            a_r    <= quo_next_s;
            cnt_r  <= cnt_r + CNT_ONE;
        end else begin
            cnt_r  <= {CNT_W{1'b0}};
        end
    end

    // Architectural HI/LO: direct write, divide-by-zero shortcut, or result.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r   <= {LENGTH{1'b0}};
            lo_r   <= {LENGTH{1'b0}};
            done_r <= 1'b0;
        end else begin
            done_r <= div_zero_s | finish_s;
            if (w_hilo) begin
                hi_r <= write_hi;
                lo_r <= write_lo;
            end else if (div_zero_s) begin
                hi_r <= src_a;
                lo_r <= {LENGTH{1'b1}};
            end else if (finish_s && (state_r == ST_MUL)) begin
                hi_r <= mul_hi_next_s;
                lo_r <= mul_lo_next_s;
            end else if (finish_s && (state_r == ST_DIV)) begin
                hi_r <= rem_next_s;
                lo_r <= quo_next_s;
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// ----------------------------------------------------------------------------
// tb_hilo_muldiv
//
// Directed self-checking bench for hilo_muldiv (LENGTH = 32). Inputs are
// driven and outputs sampled 1 ns after each rising edge.
// ----------------------------------------------------------------------------
module tb_hilo_muldiv;

    localparam int L = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [L-1:0] src_a;
    logic [L-1:0] src_b;
    logic         w_hilo;
    logic [L-1:0] write_hi;
    logic [L-1:0] write_lo;
    logic [L-1:0] hi;
    logic [L-1:0] lo;
    logic         busy;
    logic         done;

    int pass_cnt;
    int total_cnt;
    int cyc;
    int seen_done;

    hilo_muldiv #(.LENGTH(L)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .w_hilo   (w_hilo),
        .write_hi (write_hi),
        .write_lo (write_lo),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present a one-cycle start, then scramble the operand inputs.
    task automatic issue(input logic [1:0] o, input logic [L-1:0] a, input logic [L-1:0] b);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        op    = 2'b00;
        src_a = $urandom;
        src_b = $urandom;
    endtask

    // Continue counting busy cycles from c0 until busy falls (bounded).
    task automatic wait_idle(input int c0, output int c);
        c = c0;
        while ((busy === 1'b1) && (c < 200)) begin
            tick();
            if (busy === 1'b1) c++;
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        start     = 1'b0;
        op        = 2'b00;
        src_a     = 32'h0000_0000;
        src_b     = 32'h0000_0000;
        w_hilo    = 1'b0;
        write_hi  = 32'h0000_0000;
        write_lo  = 32'h0000_0000;

        // Reset, then idle.
        tick(); tick();
        check("rst_hi", 64'(hi), 64'h0);
        check("rst_lo", 64'(lo), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("idle_hi", 64'(hi), 64'h0);
        check("idle_lo", 64'(lo), 64'h0);
        check("idle_busy", 64'(busy), 64'h0);
        check("idle_done", 64'(done), 64'h0);

        // MULTU FFFFFFFF * 2 = 1_FFFFFFFE.
        issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0002);
        check("mul_busy_e0", 64'(busy), 64'h1);
        check("mul_hold_hi_e0", 64'(hi), 64'h0);
        for (int i = 0; i < 15; i++) tick();
        check("mul_hold_hi_mid", 64'(hi), 64'h0);
        check("mul_hold_lo_mid", 64'(lo), 64'h0);
        check("mul_done_mid", 64'(done), 64'h0);
        wait_idle(16, cyc);
        check("mul_busy_cycles", 64'(cyc), 64'd32);
        check("mul_hi", 64'(hi), 64'h0000_0001);
        check("mul_lo", 64'(lo), 64'hFFFF_FFFE);
        check("mul_done", 64'(done), 64'h1);
        tick();
        check("mul_done_pulse", 64'(done), 64'h0);

        // DIVU 100 / 7 = 14 r 2.
        issue(2'b10, 32'd100, 32'd7);
        wait_idle(1, cyc);
        check("div_busy_cycles", 64'(cyc), 64'd32);
        check("div_lo", 64'(lo), 64'd14);
        check("div_hi", 64'(hi), 64'd2);
        check("div_done", 64'(done), 64'h1);
        tick();
        check("div_done_pulse", 64'(done), 64'h0);

        // Divide by zero completes at once.
        issue(2'b10, 32'd5, 32'd0);
        check("dz_hi", 64'(hi), 64'd5);
        check("dz_lo", 64'(lo), 64'hFFFF_FFFF);
        check("dz_busy", 64'(busy), 64'h0);
        check("dz_done", 64'(done), 64'h1);
        tick();
        check("dz_done_pulse", 64'(done), 64'h0);
        check("dz_busy_after", 64'(busy), 64'h0);

        // Direct write in IDLE, with a simultaneous start that must be ignored.
        w_hilo   = 1'b1;
        write_hi = 32'hA5A5_A5A5;
        write_lo = 32'h5A5A_5A5A;
        issue(2'b01, 32'd9, 32'd9);
        w_hilo   = 1'b0;
        check("wr_hi", 64'(hi), 64'hA5A5_A5A5);
        check("wr_lo", 64'(lo), 64'h5A5A_5A5A);
        check("wr_start_ignored", 64'(busy), 64'h0);

        // Abort MULTU 3*4 with a direct write at iteration 10.
        issue(2'b01, 32'd3, 32'd4);
        for (int i = 0; i < 9; i++) tick();
        check("abort_busy_before", 64'(busy), 64'h1);
        w_hilo   = 1'b1;
        write_hi = 32'd1;
        write_lo = 32'd2;
        tick();
        w_hilo   = 1'b0;
        check("abort_hi", 64'(hi), 64'd1);
        check("abort_lo", 64'(lo), 64'd2);
        check("abort_busy", 64'(busy), 64'h0);
        seen_done = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done === 1'b1) seen_done = 1;
        end
        check("abort_no_done", 64'(seen_done), 64'h0);
        check("abort_hi_kept", 64'(hi), 64'd1);
        check("abort_lo_kept", 64'(lo), 64'd2);

        // Start while busy is ignored.
        issue(2'b10, 32'd100, 32'd7);
        for (int i = 0; i < 4; i++) tick();
        op    = 2'b01;
        src_a = 32'd55;
        src_b = 32'd66;
        start = 1'b1;
        tick();
        start = 1'b0;
        op    = 2'b00;
        wait_idle(6, cyc);
        check("ign_busy_cycles", 64'(cyc), 64'd32);
        check("ign_lo", 64'(lo), 64'd14);
        check("ign_hi", 64'(hi), 64'd2);
        tick();

        // Reset in the middle of MULTU.
        issue(2'b01, 32'd1234, 32'd5678);
        for (int i = 0; i < 19; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rmid_hi", 64'(hi), 64'h0);
        check("rmid_lo", 64'(lo), 64'h0);
        check("rmid_busy", 64'(busy), 64'h0);
        seen_done = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done === 1'b1) seen_done = 1;
        end
        check("rmid_no_done", 64'(seen_done), 64'h0);

        // Back-to-back: MULTU 6*7 issued in the done cycle of DIVU 100/7.
        issue(2'b10, 32'd100, 32'd7);
        wait_idle(1, cyc);
        check("b2b_div_done", 64'(done), 64'h1);
        issue(2'b01, 32'd6, 32'd7);
        check("b2b_busy", 64'(busy), 64'h1);
        check("b2b_lo_hold", 64'(lo), 64'd14);
        wait_idle(1, cyc);
        check("b2b_busy_cycles", 64'(cyc), 64'd32);
        check("b2b_lo", 64'(lo), 64'd42);
        check("b2b_hi", 64'(hi), 64'd0);
        check("b2b_done", 64'(done), 64'h1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
